alu_issue_stage: RTL and testbench

- ID/EX issue stage sitting directly upstream of the ALU.
- Accepts one RV32I instruction plus its register-file read data per handshake, decodes it to the 4-bit ALU opcode, and selects operand_0/operand_1.
- Presents the result on a registered valid/ready interface, with a 2-entry skid buffer for full throughput under backpressure.
- Also keeps a saturating count of issued instructions.

---
 rtl/alu_pkg.sv | 76 +++++++
 rtl/alu_issue_stage_if.sv | 35 +++
 rtl/alu_decode.sv | 96 +++++++++
 rtl/alu_issue_stage.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU issue path.
//   - 4-bit ALU opcode encodings consumed by the EX stage (0101 is unused)
//   - RV32I major opcodes and funct3/funct7 field values used by the decoder
//   - skid buffer occupancy states for the issue stage
//   - helpers that map funct3/funct7 onto an ALU opcode
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALU opcodes
    localparam logic [3:0] ADD            = 4'b0000;
    localparam logic [3:0] SUB            = 4'b0001;
    localparam logic [3:0] AND            = 4'b0010;
    localparam logic [3:0] OR             = 4'b0011;
    localparam logic [3:0] XOR            = 4'b0100;
    localparam logic [3:0] SHL_LOGICAL    = 4'b0110;
    localparam logic [3:0] SHR_LOGICAL    = 4'b0111;
    localparam logic [3:0] SHR_ARITHMETIC = 4'b1000;
    localparam logic [3:0] LESS_THAN      = 4'b1001;

    // RV32I major opcodes handled by the ALU
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 values shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 values (also imm[11:5] for immediate shifts)
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // How many instructions the issue stage currently holds
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // funct7 is only free to be F7_ALT for ADD/SUB and SRL/SRA; SLTU is never supported
    function automatic logic funct7Legal(input logic [2:0] funct3, input logic [6:0] funct7);
        logic ok;
        case (funct3)
            F3_SLTU:                ok = 1'b0;
            F3_ADD_SUB, F3_SRL_SRA: ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            default:                ok = (funct7 == F7_BASE);
        endcase
        return ok;
    endfunction

    // Maps funct3 (with funct7 selecting the SUB/SRA variants) to an ALU opcode
    function automatic logic [3:0] selectAluOp(input logic [2:0] funct3, input logic [6:0] funct7);
        logic [3:0] op;
        case (funct3)
            F3_ADD_SUB: op = (funct7 == F7_ALT) ? SUB : ADD;
            F3_SLL:     op = SHL_LOGICAL;
            F3_SLT:     op = LESS_THAN;
            F3_SLTU:    op = ADD;
            F3_XOR:     op = XOR;
            F3_SRL_SRA: op = (funct7 == F7_ALT) ? SHR_ARITHMETIC : SHR_LOGICAL;
            F3_OR:      op = OR;
            F3_AND:     op = AND;
            default:    op = ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if
// Handshake bundle around the ALU issue stage.
//   in_valid/in_ready  + instr, rs1_data, rs2_data   : instruction side
//   out_valid/out_ready + opcode, operand_0, operand_1, rd, illegal : ALU side
// Modports:
//   master - surrounding pipeline: supplies instructions, consumes ALU ops
//   slave  - the issue stage itself
// ---------------------------------------------------------------------------
interface alu_issue_stage_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      opcode;
    logic [XLEN-1:0] operand_0;
    logic [XLEN-1:0] operand_1;
    logic [4:0]      rd;
    logic            illegal;

    modport master (
        output in_valid, instr, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, opcode, operand_0, operand_1, rd, illegal
    );

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, opcode, operand_0, operand_1, rd, illegal
    );
endinterface

// File: rtl/alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
// Purely combinational RV32I -> ALU decoder.
//   i_instr     : instruction word
//   i_rs1Data   : x[rs1]
//   i_rs2Data   : x[rs2]
//   o_opcode    : 4-bit ALU opcode
//   o_operand0  : first ALU operand
//   o_operand1  : second ALU operand
//   o_rd        : destination register
//   o_illegal   : instruction cannot be executed by the ALU
// Illegal instructions come out as ADD 0,0 -> x0 so they retire harmlessly.
// ---------------------------------------------------------------------------
module alu_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs1Data,
    input  logic [XLEN-1:0] i_rs2Data,
    output logic [3:0]      o_opcode,
    output logic [XLEN-1:0] o_operand0,
    output logic [XLEN-1:0] o_operand1,
    output logic [4:0]      o_rd,
    output logic            o_illegal
);

    logic [6:0]      w_major;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_isShift;
    logic [XLEN-1:0] w_immSext;
    logic [XLEN-1:0] w_shamt;
    logic [XLEN-1:0] w_luiImm;
    logic [3:0]      w_opcode;
    logic [XLEN-1:0] w_operand0;
    logic [XLEN-1:0] w_operand1;
    logic            w_illegal;
    logic            w_unusedRs1Field;

    assign w_major   = i_instr[6:0];
    assign w_funct3  = i_instr[14:12];
    assign w_funct7  = i_instr[31:25];
    assign w_isShift = (w_funct3 == F3_SLL) || (w_funct3 == F3_SRL_SRA);
    assign w_immSext = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_shamt   = {{(XLEN-5){1'b0}}, i_instr[24:20]};
    assign w_luiImm  = {i_instr[31:12], 12'b0};

    // The rs1 index was already used upstream to read the register file
    assign w_unusedRs1Field = ^i_instr[19:15];

    // Raw decode by major opcode; immediate shifts reuse the OP funct7 rules on imm[11:5]
    always_comb begin
        w_opcode   = ADD;
        w_operand0 = '0;
        w_operand1 = '0;
        w_illegal  = 1'b0;
        case (w_major)
            OPC_OP: begin
                w_operand0 = i_rs1Data;
                w_operand1 = i_rs2Data;
                w_opcode   = selectAluOp(w_funct3, w_funct7);
                w_illegal  = !funct7Legal(w_funct3, w_funct7);
            end
            OPC_OP_IMM: begin
                w_operand0 = i_rs1Data;
                if (w_isShift) begin
                    w_operand1 = w_shamt;
                    w_opcode   = selectAluOp(w_funct3, w_funct7);
                    w_illegal  = !funct7Legal(w_funct3, w_funct7);
                end else begin
                    w_operand1 = w_immSext;
                    w_opcode   = selectAluOp(w_funct3, F7_BASE);
                    w_illegal  = (w_funct3 == F3_SLTU);
                end
            end
            OPC_LUI: begin
                w_operand1 = w_luiImm;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Squash illegal instructions into a no-op write of zero to x0
    always_comb begin
        o_illegal  = w_illegal;
        o_opcode   = w_illegal ? ADD : w_opcode;
        o_operand0 = w_illegal ? '0 : w_operand0;
        o_operand1 = w_illegal ? '0 : w_operand1;
        o_rd       = w_illegal ? 5'd0 : i_instr[11:7];
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX issue stage in front of the ALU: decodes one instruction per
// handshake and presents it on a registered output with a one-entry skid so
// the stage keeps full throughput under backpressure.
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   flush        : drop everything held in the stage
//   bus          : alu_issue_stage_if.slave (instruction in, ALU op out)
//   issued_count : saturating count of output handshakes (not cleared by flush)
// ---------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_issue_stage_if.slave   bus,
    output logic [CNT_W-1:0]   issued_count
);

    skid_state_e r_state;
    skid_state_e w_nextState;

    logic [3:0]      r_opcode,    r_skidOpcode;
    logic [XLEN-1:0] r_operand0,  r_skidOperand0;
    logic [XLEN-1:0] r_operand1,  r_skidOperand1;
    logic [4:0]      r_rd,        r_skidRd;
    logic            r_illegal,   r_skidIllegal;
    logic [CNT_W-1:0] r_issuedCount;

    logic [3:0]      w_decOpcode;
    logic [XLEN-1:0] w_decOperand0;
    logic [XLEN-1:0] w_decOperand1;
    logic [4:0]      w_decRd;
    logic            w_decIllegal;

    logic w_inReady;
    logic w_outValid;
    logic w_accept;
    logic w_drain;
    logic w_loadOutFromDecode;
    logic w_loadOutFromSkid;
    logic w_loadSkid;

    alu_decode #(.XLEN(XLEN)) u_decode (
        .i_instr    (bus.instr),
        .i_rs1Data  (bus.rs1_data),
        .i_rs2Data  (bus.rs2_data),
        .o_opcode   (w_decOpcode),
        .o_operand0 (w_decOperand0),
        .o_operand1 (w_decOperand1),
        .o_rd       (w_decRd),
        .o_illegal  (w_decIllegal)
    );

    // Both handshake flags are pure decodes of the state register, so neither
    // has a combinational path from the downstream ready
    assign w_inReady  = (r_state != SKID_FULL);
    assign w_outValid = (r_state != SKID_EMPTY);
    assign w_accept   = bus.in_valid && w_inReady;
    assign w_drain    = w_outValid && bus.out_ready;

    // Occupancy register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Occupancy moves up on accept, down on drain; flush empties the stage
    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: if (w_accept) w_nextState = SKID_ONE;
                SKID_ONE: begin
                    if (w_drain && !w_accept)      w_nextState = SKID_EMPTY;
                    else if (!w_drain && w_accept) w_nextState = SKID_FULL;
                end
                SKID_FULL:  if (w_drain) w_nextState = SKID_ONE;
                default:    w_nextState = SKID_EMPTY;
            endcase
        end
    end

    // Datapath load enables: the output register refills from the decoder when
    // it is free or draining, from the skid when the skid is occupied; the skid
    // only captures when the output register is stalled
    always_comb begin
        w_loadOutFromDecode = 1'b0;
        w_loadOutFromSkid   = 1'b0;
        w_loadSkid          = 1'b0;
        if (!flush) begin
            case (r_state)
                SKID_EMPTY: w_loadOutFromDecode = w_accept;
                SKID_ONE: begin
                    w_loadOutFromDecode = w_accept && w_drain;
                    w_loadSkid          = w_accept && !w_drain;
                end
                SKID_FULL:  w_loadOutFromSkid = w_drain;
                default: ;
            endcase
        end
    end

    // Output and skid payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode       <= ADD;
            r_operand0     <= '0;
            r_operand1     <= '0;
            r_rd           <= 5'd0;
            r_illegal      <= 1'b0;
            r_skidOpcode   <= ADD;
            r_skidOperand0 <= '0;
            r_skidOperand1 <= '0;
            r_skidRd       <= 5'd0;
            r_skidIllegal  <= 1'b0;
        end else begin
            if (w_loadOutFromDecode) begin
                r_opcode   <= w_decOpcode;
                r_operand0 <= w_decOperand0;
                r_operand1 <= w_decOperand1;
                r_rd       <= w_decRd;
                r_illegal  <= w_decIllegal;
            end else if (w_loadOutFromSkid) begin
                r_opcode   <= r_skidOpcode;
                r_operand0 <= r_skidOperand0;
                r_operand1 <= r_skidOperand1;
                r_rd       <= r_skidRd;
                r_illegal  <= r_skidIllegal;
            end
            if (w_loadSkid) begin
                r_skidOpcode   <= w_decOpcode;
                r_skidOperand0 <= w_decOperand0;
                r_skidOperand1 <= w_decOperand1;
                r_skidRd       <= w_decRd;
                r_skidIllegal  <= w_decIllegal;
            end
        end
    end

    // Issue counter; a handshake in a flush cycle still counts, flush never clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issuedCount <= '0;
        end else if (w_drain && (r_issuedCount != {CNT_W{1'b1}})) begin
            r_issuedCount <= r_issuedCount + 1'b1;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.opcode    = r_opcode;
    assign bus.operand_0 = r_operand0;
    assign bus.operand_1 = r_operand1;
    assign bus.rd        = r_rd;
    assign bus.illegal   = r_illegal;
    assign issued_count  = r_issuedCount;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed bench for alu_issue_stage. A queue-based model of the stage's
// contents is compared against the DUT on every falling edge, and hand-worked
// literal values pin the model at key points. The counter is narrowed to
// 5 bits so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] issuedCount;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .issued_count (issuedCount)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [4:0]  rd;
        logic        illegal;
    } expect_t;

    expect_t expQ[$];
    int      expCount = 0;
    logic [31:0] tbl[12];

    // Single comparison point for both the model checks and the literal checks
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // funct3 -> ALU opcode straight from the decode table; -1 marks unsupported
    function automatic int baseOp(input logic [2:0] f3);
        case (f3)
            3'd0: return 0;
            3'd1: return 6;
            3'd2: return 9;
            3'd4: return 4;
            3'd5: return 7;
            3'd6: return 3;
            3'd7: return 2;
            default: return -1;
        endcase
    endfunction

    // What the ALU should see for one instruction
    function automatic expect_t modelDecode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        expect_t e;
        int code;
        logic [6:0] maj;
        logic [2:0] f3;
        logic [6:0] f7;
        logic shift;
        maj   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        e     = '0;
        code  = -1;
        if (maj == 7'b0110011 || maj == 7'b0010011) begin
            e.op0 = a;
            if (maj == 7'b0110011) e.op1 = b;
            else if (shift)        e.op1 = {27'b0, ins[24:20]};
            else                   e.op1 = {{20{ins[31]}}, ins[31:20]};
            if (maj == 7'b0110011 || shift) begin
                if (f7 == 7'h00)                   code = baseOp(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
                else if (f7 == 7'h20 && f3 == 3'd5) code = 8;
            end else begin
                code = baseOp(f3);
            end
        end else if (maj == 7'b0110111) begin
            e.op0 = 32'd0;
            e.op1 = {ins[31:12], 12'b0};
            code  = 0;
        end
        if (code < 0) begin
            e = '0;
            e.illegal = 1'b1;
        end else begin
            e.opcode = code[3:0];
            e.rd     = ins[11:7];
        end
        return e;
    endfunction

    // Cycle-by-cycle comparison against the model, then advance the model by the upcoming edge
    initial begin
        logic drain;
        logic accept;
        @(negedge clk);
        forever begin
            checkOutput("cycle in_ready", {31'b0, bus.in_ready}, {31'b0, expQ.size() < 2});
            checkOutput("cycle out_valid", {31'b0, bus.out_valid}, {31'b0, expQ.size() > 0});
            checkOutput("cycle issued_count", 32'(issuedCount), 32'(expCount));
            if (bus.out_valid && expQ.size() > 0) begin
                checkOutput("cycle opcode", 32'(bus.opcode), 32'(expQ[0].opcode));
                checkOutput("cycle operand_0", bus.operand_0, expQ[0].op0);
                checkOutput("cycle operand_1", bus.operand_1, expQ[0].op1);
                checkOutput("cycle rd", 32'(bus.rd), 32'(expQ[0].rd));
                checkOutput("cycle illegal", {31'b0, bus.illegal}, {31'b0, expQ[0].illegal});
            end
            if (rst) begin
                expQ.delete();
                expCount = 0;
            end else begin
                drain  = (expQ.size() > 0) && bus.out_ready;
                accept = bus.in_valid && (expQ.size() < 2);
                if (drain && expCount < CNT_MAX) expCount++;
                if (flush) begin
                    expQ.delete();
                end else begin
                    if (drain)  void'(expQ.pop_front());
                    if (accept) expQ.push_back(modelDecode(bus.instr, bus.rs1_data, bus.rs2_data));
                end
            end
            @(negedge clk);
        end
    end

    // Holds in_valid until the stage takes the word, with a bounded wait
    task automatic waitAccept();
        int   n;
        logic taken;
        n = 0;
        taken = 1'b0;
        while (!taken && n < 20) begin
            taken = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("accept within bound", {31'b0, taken}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_data = a;
        bus.rs2_data = b;
        waitAccept();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = 32'd0;
        bus.rs1_data  = 32'd0;
        bus.rs2_data  = 32'd0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) stepCycle();

        // Reset state
        checkOutput("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset opcode", 32'(bus.opcode), 32'd0);
        checkOutput("reset operand_0", bus.operand_0, 32'd0);
        checkOutput("reset operand_1", bus.operand_1, 32'd0);
        checkOutput("reset rd", 32'(bus.rd), 32'd0);
        checkOutput("reset illegal", {31'b0, bus.illegal}, 32'd0);
        checkOutput("reset issued_count", 32'(issuedCount), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        stepCycle();

        // add x3,x1,x2
        applyStimulus(32'h002081B3, 32'd5, 32'd7);
        idle();
        checkOutput("add out_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("add opcode", 32'(bus.opcode), 32'h0);
        checkOutput("add operand_0", bus.operand_0, 32'd5);
        checkOutput("add operand_1", bus.operand_1, 32'd7);
        checkOutput("add rd", 32'(bus.rd), 32'd3);
        checkOutput("add illegal", {31'b0, bus.illegal}, 32'd0);
        stepCycle();
        checkOutput("add issued_count", 32'(issuedCount), 32'd1);

        // sub then addi x5,x0,-1 back to back
        applyStimulus(32'h402081B3, 32'd9, 32'd4);
        checkOutput("sub opcode", 32'(bus.opcode), 32'h1);
        applyStimulus(32'hFFF00293, 32'd0, 32'd123);
        idle();
        checkOutput("addi opcode", 32'(bus.opcode), 32'h0);
        checkOutput("addi operand_0", bus.operand_0, 32'd0);
        checkOutput("addi operand_1", bus.operand_1, 32'hFFFFFFFF);
        checkOutput("addi rd", 32'(bus.rd), 32'd5);
        stepCycle();

        // srai x6,x1,4
        applyStimulus(32'h4040D313, 32'hF0000000, 32'd77);
        idle();
        checkOutput("srai opcode", 32'(bus.opcode), 32'h8);
        checkOutput("srai operand_0", bus.operand_0, 32'hF0000000);
        checkOutput("srai operand_1", bus.operand_1, 32'd4);
        checkOutput("srai rd", 32'(bus.rd), 32'd6);
        stepCycle();

        // lui x7,0x12345
        applyStimulus(32'h123453B7, 32'h0000AAAA, 32'h0000BBBB);
        idle();
        checkOutput("lui opcode", 32'(bus.opcode), 32'h0);
        checkOutput("lui operand_0", bus.operand_0, 32'd0);
        checkOutput("lui operand_1", bus.operand_1, 32'h12345000);
        checkOutput("lui rd", 32'(bus.rd), 32'd7);
        stepCycle();

        // sltu is not supported
        applyStimulus(32'h0020B1B3, 32'd3, 32'd4);
        idle();
        checkOutput("sltu illegal", {31'b0, bus.illegal}, 32'd1);
        checkOutput("sltu opcode", 32'(bus.opcode), 32'h0);
        checkOutput("sltu operand_0", bus.operand_0, 32'd0);
        checkOutput("sltu operand_1", bus.operand_1, 32'd0);
        checkOutput("sltu rd", 32'(bus.rd), 32'd0);
        stepCycle();
        checkOutput("after six issued_count", 32'(issuedCount), 32'd6);

        // Remaining decode table, model-checked, back to back
        tbl[0]  = rType(7'h00, 5'd2, 5'd1, 3'd7, 5'd8);
        tbl[1]  = rType(7'h00, 5'd2, 5'd1, 3'd6, 5'd9);
        tbl[2]  = rType(7'h00, 5'd2, 5'd1, 3'd4, 5'd10);
        tbl[3]  = rType(7'h00, 5'd2, 5'd1, 3'd1, 5'd11);
        tbl[4]  = rType(7'h00, 5'd2, 5'd1, 3'd5, 5'd12);
        tbl[5]  = rType(7'h20, 5'd2, 5'd1, 3'd5, 5'd13);
        tbl[6]  = rType(7'h00, 5'd2, 5'd1, 3'd2, 5'd14);
        tbl[7]  = iType(12'h800, 5'd1, 3'd2, 5'd15);
        tbl[8]  = iType(12'h7FF, 5'd1, 3'd7, 5'd16);
        tbl[9]  = rType(7'h01, 5'd2, 5'd1, 3'd0, 5'd17);
        tbl[10] = 32'h00002083;
        tbl[11] = iType(12'h01F, 5'd1, 3'd1, 5'd18);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], $urandom, $urandom);
        end
        idle();
        stepCycle();
        checkOutput("table issued_count", 32'(issuedCount), 32'd18);

        // Backpressure: A held, B in skid, C waits
        bus.out_ready = 1'b0;
        applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd20), 32'h11, 32'h22);
        applyStimulus(rType(7'h20, 5'd2, 5'd1, 3'd0, 5'd21), 32'h33, 32'h44);
        bus.instr    = iType(12'h00A, 5'd1, 3'd4, 5'd22);
        bus.rs1_data = 32'h55;
        bus.rs2_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall in_ready", {31'b0, bus.in_ready}, 32'd0);
            checkOutput("stall out_valid", {31'b0, bus.out_valid}, 32'd1);
            checkOutput("stall operand_0", bus.operand_0, 32'h11);
            checkOutput("stall rd", 32'(bus.rd), 32'd20);
            stepCycle();
        end
        bus.out_ready = 1'b1;
        waitAccept();
        idle();
        checkOutput("drain third rd", 32'(bus.rd), 32'd22);
        checkOutput("drain third opcode", 32'(bus.opcode), 32'h4);
        checkOutput("drain third operand_1", bus.operand_1, 32'h0000000A);
        stepCycle();
        checkOutput("drain issued_count", 32'(issuedCount), 32'd21);

        // Flush with a full stage and a pending instruction
        bus.out_ready = 1'b0;
        applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd6, 5'd23), 32'h1, 32'h2);
        applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd7, 5'd24), 32'h3, 32'h4);
        bus.instr = rType(7'h00, 5'd2, 5'd1, 3'd4, 5'd25);
        checkOutput("full in_ready", {31'b0, bus.in_ready}, 32'd0);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        idle();
        checkOutput("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("flush issued_count", 32'(issuedCount), 32'd21);

        // A handshake in the flush cycle is discarded
        bus.in_valid = 1'b1;
        bus.instr    = rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd26);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        idle();
        checkOutput("flush drop out_valid", {31'b0, bus.out_valid}, 32'd0);
        stepCycle();
        checkOutput("flush drop still empty", {31'b0, bus.out_valid}, 32'd0);

        // Flow resumes after flush: ori x9,x1,5
        bus.out_ready = 1'b1;
        applyStimulus(iType(12'h005, 5'd1, 3'd6, 5'd9), 32'h30, 32'd0);
        idle();
        checkOutput("resume opcode", 32'(bus.opcode), 32'h3);
        checkOutput("resume operand_1", bus.operand_1, 32'd5);
        checkOutput("resume rd", 32'(bus.rd), 32'd9);
        stepCycle();
        checkOutput("resume issued_count", 32'(issuedCount), 32'd22);

        // Counter saturation: 22 + 15 clamps at 31
        for (int i = 0; i < 15; i++) begin
            applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd0, 5'(i + 1)), 32'(i), 32'd1);
        end
        idle();
        repeat (2) stepCycle();
        checkOutput("saturated issued_count", 32'(issuedCount), 32'd31);

        // Reset while holding two instructions
        bus.out_ready = 1'b0;
        applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd7, 5'd27), 32'h7, 32'h8);
        applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd6, 5'd28), 32'h9, 32'hA);
        idle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midreset out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("midreset in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("midreset issued_count", 32'(issuedCount), 32'd0);
        checkOutput("midreset rd", 32'(bus.rd), 32'd0);
        stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
